// File: rtl/risc_core_pkg.sv
// Shared definitions for the multi-cycle RISC core: opcodes, FSM state encoding and
// the instruction field layout.
package risc_core_pkg;

   localparam int unsigned NumRegs  = 16;
   localparam int unsigned RegAddrW = 4;

   localparam logic [3:0] OpAdd  = 4'h0;
   localparam logic [3:0] OpSub  = 4'h1;
   localparam logic [3:0] OpAnd  = 4'h2;
   localparam logic [3:0] OpOr   = 4'h3;
   localparam logic [3:0] OpXor  = 4'h4;
   localparam logic [3:0] OpSlt  = 4'h5;
   localparam logic [3:0] OpSll  = 4'h6;
   localparam logic [3:0] OpSrl  = 4'h7;
   localparam logic [3:0] OpLi   = 4'h8;
   localparam logic [3:0] OpLw   = 4'h9;
   localparam logic [3:0] OpSw   = 4'hA;
   localparam logic [3:0] OpBeq  = 4'hB;
   localparam logic [3:0] OpBne  = 4'hC;
   localparam logic [3:0] OpJmp  = 4'hD;
   localparam logic [3:0] OpNop  = 4'hE;
   localparam logic [3:0] OpHalt = 4'hF;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   // imm8 is {rt, rd}; imm4 is rd.
   typedef struct packed {
      logic [3:0] op;
      logic [3:0] rs;
      logic [3:0] rt;
      logic [3:0] rd;
   } instr_t;

endpackage

// File: rtl/core_regfile.sv
// 16-entry register file with two asynchronous read ports and one synchronous write port.
// R0 always reads as zero and ignores writes; synchronous clear on reset.
module core_regfile
   import risc_core_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_we,
   input  logic [RegAddrW-1:0] i_waddr,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [RegAddrW-1:0] i_raddr_a,
   input  logic [RegAddrW-1:0] i_raddr_b,
   output logic [DATA_W-1:0]   o_rdata_a,
   output logic [DATA_W-1:0]   o_rdata_b
);

   logic [DATA_W-1:0] r_regs [NumRegs];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < NumRegs; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
   assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/risc_multicycle_core.sv
// Multi-cycle 16-bit-instruction RISC core with req/ack instruction and data memory ports.
// FETCH/DECODE/EXEC/MEM/WB/HALT sequencing; all bus outputs are registered.
module risc_multicycle_core
   import risc_core_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned PC_W    = 8,
   parameter int unsigned DADDR_W = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   output logic               o_imem_req,
   output logic [PC_W-1:0]    o_imem_addr,
   input  logic               i_imem_ack,
   input  logic [15:0]        i_imem_rdata,
   output logic               o_dmem_req,
   output logic               o_dmem_we,
   output logic [DADDR_W-1:0] o_dmem_addr,
   output logic [DATA_W-1:0]  o_dmem_wdata,
   input  logic               i_dmem_ack,
   input  logic [DATA_W-1:0]  i_dmem_rdata,
   output logic [PC_W-1:0]    o_pc_out,
   output logic [2:0]         o_state_out,
   output logic               o_retire,
   output logic               o_halted
);

   localparam int unsigned ShW = $clog2(DATA_W);

   state_e               r_state;
   instr_t               r_instr;
   logic [PC_W-1:0]      r_pc;
   logic [DATA_W-1:0]    r_a;
   logic [DATA_W-1:0]    r_b;
   logic [DATA_W-1:0]    r_wb_data;
   logic                 r_imem_req;
   logic                 r_dmem_req;
   logic                 r_dmem_we;
   logic [DADDR_W-1:0]   r_dmem_addr;
   logic [DATA_W-1:0]    r_dmem_wdata;
   logic                 r_retire;
   logic                 r_halted;

   logic [3:0]           w_op;
   logic [7:0]           w_imm8;
   logic [3:0]           w_imm4;
   logic [ShW-1:0]       w_shamt;
   logic [DATA_W-1:0]    w_rdata_a;
   logic [DATA_W-1:0]    w_rdata_b;
   logic [DATA_W-1:0]    w_alu;
   logic [PC_W-1:0]      w_pc_inc;
   logic [PC_W-1:0]      w_pc_branch;
   logic [PC_W-1:0]      w_pc_next;
   logic [DADDR_W-1:0]   w_ea;
   logic                 w_rf_we;
   logic [RegAddrW-1:0]  w_rf_waddr;

   assign w_op    = r_instr.op;
   assign w_imm8  = {r_instr.rt, r_instr.rd};
   assign w_imm4  = r_instr.rd;
   assign w_shamt = r_b[ShW-1:0];

   core_regfile #(
      .DATA_W (DATA_W)
   ) u_regfile (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_we      (w_rf_we),
      .i_waddr   (w_rf_waddr),
      .i_wdata   (r_wb_data),
      .i_raddr_a (r_instr.rs),
      .i_raddr_b (r_instr.rt),
      .o_rdata_a (w_rdata_a),
      .o_rdata_b (w_rdata_b)
   );

   always_comb begin
      w_alu = '0;
      case (w_op)
         OpAdd:   w_alu = r_a + r_b;
         OpSub:   w_alu = r_a - r_b;
         OpAnd:   w_alu = r_a & r_b;
         OpOr:    w_alu = r_a | r_b;
         OpXor:   w_alu = r_a ^ r_b;
         OpSlt:   w_alu = DATA_W'($signed(r_a) < $signed(r_b));
         OpSll:   w_alu = r_a << w_shamt;
         OpSrl:   w_alu = r_a >> w_shamt;
         OpLi:    w_alu = DATA_W'(w_imm8);
         default: w_alu = '0;
      endcase
   end

   // Branch offset is a signed 4-bit displacement relative to pc+1.
   always_comb begin
      w_pc_inc    = r_pc + PC_W'(1);
      w_pc_branch = w_pc_inc + PC_W'($signed(w_imm4));
      w_pc_next   = w_pc_inc;
      case (w_op)
         OpBeq:   w_pc_next = (r_a == r_b) ? w_pc_branch : w_pc_inc;
         OpBne:   w_pc_next = (r_a != r_b) ? w_pc_branch : w_pc_inc;
         OpJmp:   w_pc_next = PC_W'(w_imm8);
         default: w_pc_next = w_pc_inc;
      endcase
   end

   assign w_ea = DADDR_W'(r_a) + DADDR_W'(w_imm4);

   always_comb begin
      w_rf_we    = (r_state == StWb);
      w_rf_waddr = r_instr.rd;
      if (w_op == OpLi) begin
         w_rf_waddr = r_instr.rs;
      end else if (w_op == OpLw) begin
         w_rf_waddr = r_instr.rt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StFetch;
         r_instr      <= '0;
         r_pc         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_wb_data    <= '0;
         r_imem_req   <= 1'b0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_retire     <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_retire <= 1'b0;
         unique case (r_state)
            StFetch: begin
               // Request is registered, so the first fetch after reset raises it here.
               if (!r_imem_req) begin
                  r_imem_req <= 1'b1;
               end else if (i_imem_ack) begin
                  r_imem_req <= 1'b0;
                  r_instr    <= i_imem_rdata;
                  r_state    <= StDecode;
               end
            end
            StDecode: begin
               r_a     <= w_rdata_a;
               r_b     <= w_rdata_b;
               r_state <= StExec;
            end
            StExec: begin
               r_wb_data <= w_alu;
               case (w_op)
                  OpBeq, OpBne, OpJmp, OpNop: begin
                     r_pc       <= w_pc_next;
                     r_retire   <= 1'b1;
                     r_imem_req <= 1'b1;
                     r_state    <= StFetch;
                  end
                  OpLw, OpSw: begin
                     r_dmem_req   <= 1'b1;
                     r_dmem_we    <= (w_op == OpSw);
                     r_dmem_addr  <= w_ea;
                     r_dmem_wdata <= r_b;
                     r_state      <= StMem;
                  end
                  OpHalt: begin
                     r_halted <= 1'b1;
                     r_state  <= StHalt;
                  end
                  default: r_state <= StWb;
               endcase
            end
            StMem: begin
               if (i_dmem_ack) begin
                  r_dmem_req <= 1'b0;
                  r_dmem_we  <= 1'b0;
                  if (!r_dmem_we) begin
                     r_wb_data <= i_dmem_rdata;
                     r_state   <= StWb;
                  end else begin
                     r_pc       <= w_pc_inc;
                     r_retire   <= 1'b1;
                     r_imem_req <= 1'b1;
                     r_state    <= StFetch;
                  end
               end
            end
            StWb: begin
               r_pc       <= w_pc_inc;
               r_retire   <= 1'b1;
               r_imem_req <= 1'b1;
               r_state    <= StFetch;
            end
            StHalt: r_state <= StHalt;
            default: r_state <= StFetch;
         endcase
      end
   end

   assign o_imem_req   = r_imem_req;
   assign o_imem_addr  = r_pc;
   assign o_dmem_req   = r_dmem_req;
   assign o_dmem_we    = r_dmem_we;
   assign o_dmem_addr  = r_dmem_addr;
   assign o_dmem_wdata = r_dmem_wdata;
   assign o_pc_out     = r_pc;
   assign o_state_out  = r_state;
   assign o_retire     = r_retire;
   assign o_halted     = r_halted;

endmodule

// File: tb/tb_risc_multicycle_core.sv
// Bench for risc_multicycle_core: memory models with programmable wait states and
// queue-based scoreboards for stores, retire pcs, instruction lengths and request lengths.
module tb_risc_multicycle_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_ack;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
   logic [7:0]  pc_out;
   logic [2:0]  state_out;
   logic        retire, halted;

   logic [15:0] prog [256];
   logic [7:0]  dmem [256];
   int          imem_wait = 0;
   int          dmem_wait = 0;
   int          icnt = 0;
   int          dcnt = 0;
   logic        force_dack = 1'b0;

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_st[$];
   logic [15:0] got_st[$];
   int          exp_len[$];
   int          got_len[$];
   logic [7:0]  exp_pc[$];
   logic [7:0]  got_pc[$];
   int          exp_dlen[$];
   int          got_dlen[$];
   int          unstable;
   bit          timed_out;

   always #5 clk = ~clk;

   assign imem_ack   = imem_req && (icnt == imem_wait);
   assign imem_rdata = prog[imem_addr];
   assign dmem_ack   = (dmem_req && (dcnt == dmem_wait)) || force_dack;
   assign dmem_rdata = dmem[dmem_addr];

   always @(posedge clk) begin
      if (rst) begin
         icnt <= 0;
         dcnt <= 0;
      end else begin
         icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
         dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
         if (dmem_req && dmem_ack && dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
            got_st.push_back({dmem_addr, dmem_wdata});
         end
      end
   end

   risc_multicycle_core #(
      .DATA_W  (8),
      .PC_W    (8),
      .DADDR_W (8)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .o_imem_req   (imem_req),
      .o_imem_addr  (imem_addr),
      .i_imem_ack   (imem_ack),
      .i_imem_rdata (imem_rdata),
      .o_dmem_req   (dmem_req),
      .o_dmem_we    (dmem_we),
      .o_dmem_addr  (dmem_addr),
      .o_dmem_wdata (dmem_wdata),
      .i_dmem_ack   (dmem_ack),
      .i_dmem_rdata (dmem_rdata),
      .o_pc_out     (pc_out),
      .o_state_out  (state_out),
      .o_retire     (retire),
      .o_halted     (halted)
   );

   task automatic clear_bench();
      foreach (prog[i]) prog[i] = 16'hF000;
      exp_st.delete();   got_st.delete();
      exp_len.delete();  got_len.delete();
      exp_pc.delete();   got_pc.delete();
      exp_dlen.delete(); got_dlen.delete();
      unstable   = 0;
      imem_wait  = 0;
      dmem_wait  = 0;
      force_dack = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Runs until halted, logging per-instruction cycle counts, retire pcs and data request lengths.
   task automatic run_prog(input int budget);
      int n = 0;
      int cnt = 0;
      int dlen = 0;
      bit started = 0;
      logic [16:0] d0 = '0;
      timed_out = 0;
      while (!halted) begin
         if (n >= budget) begin
            timed_out = 1;
            break;
         end
         @(negedge clk);
         n++;
         if (!started && imem_req) started = 1;
         if (started) begin
            if (retire) begin
               got_len.push_back(cnt);
               got_pc.push_back(pc_out);
               cnt = 0;
            end
            cnt++;
         end
         if (dmem_req) begin
            if (dlen == 0) d0 = {dmem_we, dmem_addr, dmem_wdata};
            else if (d0 !== {dmem_we, dmem_addr, dmem_wdata}) unstable++;
            dlen++;
            if (dmem_ack) begin
               got_dlen.push_back(dlen);
               dlen = 0;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (state_out !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", state_out); end
      total++; if (pc_out !== 8'd0) begin bad++; $display("FAIL rst_pc got=%0d want=0", pc_out); end
      total++; if ({imem_req, dmem_req, dmem_we} !== 3'b000) begin
         bad++; $display("FAIL rst_req got=%b want=000", {imem_req, dmem_req, dmem_we}); end
      total++; if ({retire, halted} !== 2'b00) begin
         bad++; $display("FAIL rst_flags got=%b want=00", {retire, halted}); end
      total++; if ({dmem_addr, dmem_wdata} !== 16'h0000) begin
         bad++; $display("FAIL rst_dbus got=%h want=0000", {dmem_addr, dmem_wdata}); end
      rst = 1'b0;
      @(negedge clk);
      total++; if ({imem_req, imem_addr} !== {1'b1, 8'd0}) begin
         bad++; $display("FAIL rst_first_fetch got=%b/%0d want=1/0", imem_req, imem_addr); end
   endtask

   task automatic test_alu_basic();
      logic [15:0] p[$] = '{16'h8105, 16'h8203, 16'h0123, 16'hA030, 16'hF000};
      clear_bench();
      foreach (p[i]) prog[i] = p[i];
      exp_st.push_back({8'd0, 8'(5 + 3)});
      apply_reset();
      run_prog(200);
      total++; if (timed_out) begin bad++; $display("FAIL t1_timeout got=timeout want=halt"); end
      total++; if (got_len[0] + got_len[1] + got_len[2] !== 12) begin
         bad++; $display("FAIL t1_cycles got=%0d want=12", got_len[0] + got_len[1] + got_len[2]); end
      total++; if (got_pc[2] !== 8'd3) begin bad++; $display("FAIL t1_pc got=%0d want=3", got_pc[2]); end
      total++; if (got_len.size() != 4) begin
         bad++; $display("FAIL t1_retires got=%0d want=4", got_len.size()); end
      total++; if (got_st.size() != 1 || got_st[0] !== exp_st[0]) begin
         bad++; $display("FAIL t1_store got=%0d/%h want=1/%h", got_st.size(), got_st[0], exp_st[0]); end
   endtask

   task automatic test_alu_ops();
      logic [15:0] p[$] = '{16'h8105, 16'h8203, 16'h1214, 16'h5415, 16'h6126, 16'h2128, 16'h3129,
                            16'h412A, 16'h742B, 16'h514C, 16'h0120, 16'h8DF0, 16'hA041, 16'hA052,
                            16'hA063, 16'hA084, 16'hA095, 16'hA0A6, 16'hA0B7, 16'hA0C8, 16'hA009,
                            16'hA1DA};
      logic [15:0] g;
      clear_bench();
      foreach (p[i]) prog[i] = p[i];
      exp_st.push_back({8'd1, 8'(3 - 5)});
      exp_st.push_back({8'd2, 8'd1});
      exp_st.push_back({8'd3, 8'(5 << 3)});
      exp_st.push_back({8'd4, 8'(5 & 3)});
      exp_st.push_back({8'd5, 8'(5 | 3)});
      exp_st.push_back({8'd6, 8'(5 ^ 3)});
      exp_st.push_back({8'd7, 8'(8'hFE >> 3)});
      exp_st.push_back({8'd8, 8'd0});
      exp_st.push_back({8'd9, 8'd0});
      exp_st.push_back({8'(5 + 10), 8'hF0});
      apply_reset();
      run_prog(400);
      total++; if (timed_out) begin bad++; $display("FAIL t2_timeout got=timeout want=halt"); end
      total++; if (got_st.size() != exp_st.size()) begin
         bad++; $display("FAIL t2_store_count got=%0d want=%0d", got_st.size(), exp_st.size()); end
      foreach (exp_st[i]) begin
         g = (i < got_st.size()) ? got_st[i] : 16'hxxxx;
         total++; if (g !== exp_st[i]) begin
            bad++; $display("FAIL t2_store%0d got=%h want=%h", i, g, exp_st[i]); end
      end
   endtask

   task automatic test_mem_wait();
      logic [15:0] p[$] = '{16'h8105, 16'hA014, 16'h9074, 16'hA079, 16'hF000};
      clear_bench();
      foreach (p[i]) prog[i] = p[i];
      dmem_wait = 2;
      exp_st.push_back({8'd4, 8'd5});
      exp_st.push_back({8'd9, 8'd5});
      exp_len  = '{4, 4 + 2, 5 + 2, 4 + 2};
      exp_dlen = '{3, 3, 3};
      apply_reset();
      run_prog(200);
      total++; if (timed_out) begin bad++; $display("FAIL t3_timeout got=timeout want=halt"); end
      total++; if (unstable != 0) begin
         bad++; $display("FAIL t3_stable got=%0d changes want=0", unstable); end
      total++; if (got_len != exp_len) begin
         bad++; $display("FAIL t3_lengths got=%p want=%p", got_len, exp_len); end
      total++; if (got_dlen != exp_dlen) begin
         bad++; $display("FAIL t3_req_len got=%p want=%p", got_dlen, exp_dlen); end
      total++; if (got_st != exp_st) begin
         bad++; $display("FAIL t3_stores got=%p want=%p", got_st, exp_st); end
   endtask

   task automatic test_branch();
      clear_bench();
      prog[0]   = 16'hC102;
      prog[1]   = 16'hD00A;
      prog[10]  = 16'hB11E;
      prog[9]   = 16'hD0FF;
      prog[255] = 16'h8105;
      exp_pc  = '{8'd1, 8'd10, 8'(10 + 1 - 2), 8'hFF, 8'(255 + 1), 8'(0 + 1 + 2)};
      exp_len = '{3, 3, 3, 3, 4, 3};
      apply_reset();
      run_prog(200);
      total++; if (timed_out) begin bad++; $display("FAIL t4_timeout got=timeout want=halt"); end
      total++; if (got_pc != exp_pc) begin
         bad++; $display("FAIL t4_pcs got=%p want=%p", got_pc, exp_pc); end
      total++; if (got_len != exp_len) begin
         bad++; $display("FAIL t4_lengths got=%p want=%p", got_len, exp_len); end
      clear_bench();
      prog[0]  = 16'hD00A;
      prog[10] = 16'hC11E;
      imem_wait = 1;
      exp_pc  = '{8'd10, 8'd11};
      exp_len = '{3 + 1, 3 + 1};
      apply_reset();
      run_prog(200);
      total++; if (timed_out) begin bad++; $display("FAIL t4b_timeout got=timeout want=halt"); end
      total++; if (got_pc != exp_pc) begin
         bad++; $display("FAIL t4b_pcs got=%p want=%p", got_pc, exp_pc); end
      total++; if (got_len != exp_len) begin
         bad++; $display("FAIL t4b_lengths got=%p want=%p", got_len, exp_len); end
   endtask

   task automatic test_halt();
      int busy = 0;
      clear_bench();
      prog[0] = 16'h8101;
      apply_reset();
      run_prog(100);
      total++; if (timed_out) begin bad++; $display("FAIL t5_timeout got=timeout want=halt"); end
      total++; if ({halted, state_out, pc_out} !== {1'b1, 3'd5, 8'd1}) begin
         bad++; $display("FAIL t5_halt got=%b/%0d/%0d want=1/5/1", halted, state_out, pc_out); end
      repeat (20) begin
         @(negedge clk);
         if (imem_req || dmem_req || retire || !halted) busy++;
      end
      total++; if (busy != 0) begin bad++; $display("FAIL t5_quiet got=%0d active want=0", busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if ({halted, state_out, pc_out} !== {1'b0, 3'd0, 8'd0}) begin
         bad++; $display("FAIL t5_reset got=%b/%0d/%0d want=0/0/0", halted, state_out, pc_out); end
   endtask

   task automatic test_reset_mid_mem();
      int n = 0;
      clear_bench();
      prog[0] = 16'h8105;
      prog[1] = 16'h9074;
      dmem_wait = 10;
      apply_reset();
      while (!(dmem_req && state_out == 3'd3) && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++; if (n >= 50) begin bad++; $display("FAIL t6_reach_mem got=timeout want=mem"); end
      rst = 1'b1;
      force_dack = 1'b1;
      @(negedge clk);
      total++; if ({dmem_req, state_out, pc_out} !== {1'b0, 3'd0, 8'd0}) begin
         bad++; $display("FAIL t6_abort got=%b/%0d/%0d want=0/0/0", dmem_req, state_out, pc_out); end
      @(negedge clk);
      clear_bench();
      prog[0] = 16'hA078;
      prog[1] = 16'hA019;
      exp_st.push_back({8'd8, 8'd0});
      exp_st.push_back({8'd9, 8'd0});
      rst = 1'b0;
      run_prog(200);
      total++; if (timed_out) begin bad++; $display("FAIL t6_timeout got=timeout want=halt"); end
      total++; if (got_st != exp_st) begin
         bad++; $display("FAIL t6_regs_cleared got=%p want=%p", got_st, exp_st); end
   endtask

   initial begin
      test_reset();
      test_alu_basic();
      test_alu_ops();
      test_mem_wait();
      test_branch();
      test_halt();
      test_reset_mid_mem();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
